// File: rtl/lampFPU_pkg.sv
// lampFPU_pkg: shared FPU widths, constants and types used by the sqrt/invsqrt output stage.
package lampFPU_pkg;
  localparam int LAMP_FLOAT_S_DW = 1;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW = LAMP_FLOAT_S_DW + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;
  localparam int LAMP_FLOAT_E_BIAS = 127;
  localparam int LAMP_FLOAT_E_MAX = 255;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_QNAN = 16'h7FC0;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_INF = 16'h7F80;
  localparam logic [LAMP_FLOAT_DW-1:0] LAMP_FLOAT_MAXF = 16'h7F7F;
  typedef enum logic [1:0] {RNE, RTZ, RUP, RDN} rndModeT;
  typedef struct packed {
    logic invalid;
    logic divZero;
    logic overflow;
    logic underflow;
    logic inexact;
  } sqrtFlagsT;
endpackage

// File: rtl/sqrt_round_decide.sv
// sqrt_round_decide: combinational round-increment and inexact decision from the lsb/G/R/sticky bits.
module sqrt_round_decide
  import lampFPU_pkg::*;
(
  input  logic [4:0] i_lgrs,
  input  logic       i_s,
  input  rndModeT    i_rm,
  output logic       o_incr,
  output logic       o_inexact
);
  logic w_sticky;
  always_comb begin
    w_sticky = |i_lgrs[1:0] | i_lgrs[2];
    o_inexact = i_lgrs[3] | w_sticky;
    o_incr = (i_rm == RTZ) ? 1'b0 :
             (i_rm == RUP) ? o_inexact & !i_s :
             (i_rm == RDN) ? o_inexact & i_s :
             i_lgrs[3] & (w_sticky | i_lgrs[4]);
  end
endmodule

// File: rtl/sqrt_round_pack.sv
// sqrt_round_pack: 2-stage round/bias/special-override/pack for SQRT and INV_SQRT results.
// Optional rounding-mode input enabled by `LAMP_SQRT_RMODES_EN (RNE only otherwise).
module sqrt_round_pack
  import lampFPU_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
`ifdef LAMP_SQRT_RMODES_EN
  input  logic [1:0]                 rndMode_i,
`endif
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       doInvSqrt_i,
  input  logic [LAMP_FLOAT_S_DW-1:0] s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0] e_i,
  input  logic [LAMP_FLOAT_F_DW+4:0] f_i,
  input  logic                       isZ_i,
  input  logic                       isInf_i,
  input  logic                       isSNAN_i,
  input  logic                       isQNAN_i,
  output logic [LAMP_FLOAT_DW-1:0]   res_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       isInvalid_o,
  output logic                       isDivZero_o,
  output logic                       isOverflow_o,
  output logic                       isUnderflow_o,
  output logic                       isInexact_o
);
  localparam int EW = LAMP_FLOAT_E_DW + 2;
  localparam int MW = LAMP_FLOAT_F_DW + 1;
  localparam int DW = LAMP_FLOAT_DW;
  localparam logic [EW-1:0] EMAX = EW'(LAMP_FLOAT_E_MAX);
  rndModeT w_rm;
  logic w_incr, w_inexact, w_nan, w_neg, w_sat, w_en1, w_en2, w_ovf, w_unf;
  logic signed [EW-1:0] w_eb, w_eb2;
  logic [MW:0] w_m;
  logic [DW-1:0] w_szero, w_spec_res, w_res;
  sqrtFlagsT w_spec_fl, w_fl;
  logic r1_v, r1_spec, r1_incr, r1_inexact, r1_sat, r2_v;
  logic signed [EW-1:0] r1_eb;
  logic [MW-1:0] r1_m;
  logic [DW-1:0] r1_spec_res, r2_res;
  sqrtFlagsT r1_spec_fl, r2_fl;
`ifdef LAMP_SQRT_RMODES_EN
  assign w_rm = rndModeT'(rndMode_i);
  assign w_sat = (w_rm == RTZ) | ((w_rm == RDN) & !s_i[0]);
`else
  assign w_rm = RNE;
  assign w_sat = 1'b0;
`endif
  sqrt_round_decide u_decide (
    .i_lgrs   (f_i[4:0]),
    .i_s      (s_i[0]),
    .i_rm     (w_rm),
    .o_incr   (w_incr),
    .o_inexact(w_inexact)
  );
  always_comb begin
    w_nan = isSNAN_i | isQNAN_i;
    w_neg = s_i[0] & !isZ_i;
    w_eb = {{2{e_i[LAMP_FLOAT_E_DW-1]}}, e_i} + EW'(LAMP_FLOAT_E_BIAS);
    w_szero = {s_i, {(DW-1){1'b0}}};
    w_spec_res = (w_nan | w_neg) ? LAMP_FLOAT_QNAN :
                 isZ_i ? (doInvSqrt_i ? (w_szero | LAMP_FLOAT_INF) : w_szero) :
                 doInvSqrt_i ? '0 : LAMP_FLOAT_INF;
    w_spec_fl = '0;
    w_spec_fl.invalid = w_nan ? isSNAN_i : w_neg;
    w_spec_fl.divZero = !w_nan & !w_neg & isZ_i & doInvSqrt_i;
    // mantissa all-ones plus one leaves the low F bits zero, so the carry needs no fraction mask
    w_m = {1'b0, r1_m} + (MW+1)'(r1_incr);
    w_eb2 = r1_eb + EW'(w_m[MW]);
    w_ovf = !w_eb2[EW-1] & (w_eb2 >= EMAX);
    w_unf = w_eb2[EW-1] | (w_eb2 == '0);
    w_res = r1_spec ? r1_spec_res :
            w_ovf ? (r1_sat ? LAMP_FLOAT_MAXF : LAMP_FLOAT_INF) :
            w_unf ? '0 : {1'b0, w_eb2[LAMP_FLOAT_E_DW-1:0], w_m[LAMP_FLOAT_F_DW-1:0]};
    w_fl = r1_spec_fl;
    w_fl.overflow = !r1_spec & w_ovf;
    w_fl.underflow = !r1_spec & !w_ovf & w_unf;
    w_fl.inexact = !r1_spec & (w_ovf | w_unf | r1_inexact);
  end
  assign w_en2 = !r2_v | ready_i;
  assign w_en1 = !r1_v | w_en2;
  assign ready_o = w_en1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r1_v <= 1'b0;
      r1_spec <= 1'b0;
      r1_spec_res <= '0;
      r1_spec_fl <= '0;
      r1_eb <= '0;
      r1_m <= '0;
      r1_incr <= 1'b0;
      r1_inexact <= 1'b0;
      r1_sat <= 1'b0;
      r2_v <= 1'b0;
      r2_res <= '0;
      r2_fl <= '0;
    end else begin
      if (w_en1) begin
        r1_v <= valid_i;
        if (valid_i) begin
          r1_spec <= w_nan | w_neg | isZ_i | isInf_i;
          r1_spec_res <= w_spec_res;
          r1_spec_fl <= w_spec_fl;
          r1_eb <= w_eb;
          r1_m <= f_i[LAMP_FLOAT_F_DW+4:4];
          r1_incr <= w_incr;
          r1_inexact <= w_inexact;
          r1_sat <= w_sat;
        end
      end
      if (w_en2) begin
        r2_v <= r1_v;
        if (r1_v) begin
          r2_res <= w_res;
          r2_fl <= w_fl;
        end
      end
    end
  assign res_o = r2_res;
  assign valid_o = r2_v;
  assign isInvalid_o = r2_v & r2_fl.invalid;
  assign isDivZero_o = r2_v & r2_fl.divZero;
  assign isOverflow_o = r2_v & r2_fl.overflow;
  assign isUnderflow_o = r2_v & r2_fl.underflow;
  assign isInexact_o = r2_v & r2_fl.inexact;
endmodule

// File: tb/tb_sqrt_round_pack.sv
// tb_sqrt_round_pack: random and directed stimulus checked against an arithmetic reference model.
module tb_sqrt_round_pack;
  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, ready_i = 1'b1, doInvSqrt_i = 1'b0;
  logic [0:0] s_i = '0;
  logic isZ_i = 1'b0, isInf_i = 1'b0, isSNAN_i = 1'b0, isQNAN_i = 1'b0;
  logic [7:0] e_i = '0;
  logic [11:0] f_i = '0;
  logic ready_o, valid_o, isInvalid_o, isDivZero_o, isOverflow_o, isUnderflow_o, isInexact_o;
  logic [15:0] res_o;
  logic [4:0] dut_fl;
  int errors = 0, checks = 0;
  typedef struct packed {logic [15:0] res; logic [4:0] fl;} exp_t;
  exp_t q[$];
  exp_t m;

  always #5 clk = ~clk;
  assign dut_fl = {isInvalid_o, isDivZero_o, isOverflow_o, isUnderflow_o, isInexact_o};

  sqrt_round_pack dut (
    .clk(clk), .rst(rst),
`ifdef LAMP_SQRT_RMODES_EN
    .rndMode_i(2'b00),
`endif
    .valid_i(valid_i), .ready_o(ready_o), .doInvSqrt_i(doInvSqrt_i), .s_i(s_i), .e_i(e_i), .f_i(f_i),
    .isZ_i(isZ_i), .isInf_i(isInf_i), .isSNAN_i(isSNAN_i), .isQNAN_i(isQNAN_i),
    .res_o(res_o), .valid_o(valid_o), .ready_i(ready_i),
    .isInvalid_o(isInvalid_o), .isDivZero_o(isDivZero_o), .isOverflow_o(isOverflow_o),
    .isUnderflow_o(isUnderflow_o), .isInexact_o(isInexact_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // flags = {invalid, divZero, overflow, underflow, inexact}
  function automatic exp_t model(input logic inv, input logic s, input logic [7:0] e, input logic [11:0] f,
                                 input logic z, input logic inf, input logic sn, input logic qn);
    int eb, mant, rem;
    if (sn | qn) return '{16'h7FC0, {sn, 4'b0}};
    if (s && !z) return '{16'h7FC0, 5'b10000};
    if (z) return inv ? '{{s, 15'h7F80}, 5'b01000} : '{{s, 15'h0000}, 5'b00000};
    if (inf) return inv ? '{16'h0000, 5'b0} : '{16'h7F80, 5'b0};
    eb = int'($signed(e)) + 127;
    mant = int'(f[11:4]);
    rem = int'(f[3:0]);
    if (rem > 8 || (rem == 8 && mant % 2 == 1)) mant++;
    if (mant == 256) begin
      mant = 128;
      eb++;
    end
    if (eb >= 255) return '{16'h7F80, 5'b00101};
    if (eb <= 0) return '{16'h0000, 5'b00011};
    return '{{1'b0, 8'(eb), 7'(mant - 128)}, {4'b0, rem != 0}};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      chk("rst_valid_o", valid_o, 0);
      chk("rst_res_o", res_o, 0);
      chk("rst_flags", dut_fl, 0);
    end else begin
      chk("ready_o", ready_o, q.size() < 2 || ready_i);
      if (valid_o) begin
        if (q.size() == 0) chk("spurious_valid_o", valid_o, 0);
        else begin
          chk("res_o", res_o, q[0].res);
          chk("flags", dut_fl, q[0].fl);
          if (ready_i) void'(q.pop_front());
        end
      end else chk("idle_flags", dut_fl, 0);
      if (valid_i && ready_o)
        q.push_back(model(doInvSqrt_i, s_i[0], e_i, f_i, isZ_i, isInf_i, isSNAN_i, isQNAN_i));
    end
  end

  task automatic send(input logic inv, input logic s, input logic [7:0] e, input logic [11:0] f,
                      input logic z, input logic inf, input logic sn, input logic qn);
    {doInvSqrt_i, s_i, e_i, f_i, isZ_i, isInf_i, isSNAN_i, isQNAN_i} = {inv, s, e, f, z, inf, sn, qn};
    valid_i = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (ready_o) break;
      if (t == 50) begin
        chk("accept_timeout", ready_o, 1);
        break;
      end
    end
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    #1 chk("drain_empty", q.size(), 0);
  endtask

  task automatic rand_beat();
    int k;
    k = $urandom_range(0, 9);
    doInvSqrt_i = 1'($urandom);
    e_i = $urandom_range(0, 1) ? 8'($urandom) : 8'(8'h7D + 8'($urandom_range(0, 6)));
    f_i = {1'b1, ($urandom_range(0, 3) == 0) ? 7'h7F : 7'($urandom), 4'($urandom)};
    {s_i, isZ_i, isInf_i, isSNAN_i, isQNAN_i} = '0;
    if (k == 6) s_i = 1'b1;
    if (k == 7) {s_i, isZ_i} = {1'($urandom), 1'b1};
    if (k == 8) {s_i, isInf_i} = {1'($urandom), 1'b1};
    if (k == 9) begin
      {s_i, isZ_i, isSNAN_i} = 3'($urandom);
      isQNAN_i = !isSNAN_i | 1'($urandom);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    m = model(0, 0, 8'd1, 12'h800, 0, 0, 0, 0);   chk("model_sqrt4", m, {16'h4000, 5'b00000});
    m = model(0, 0, 8'd0, 12'h818, 0, 0, 0, 0);   chk("model_tie_up", m, {16'h3F82, 5'b00001});
    m = model(0, 0, 8'd0, 12'h828, 0, 0, 0, 0);   chk("model_tie_even", m, {16'h3F82, 5'b00001});
    m = model(0, 0, 8'd0, 12'hFFC, 0, 0, 0, 0);   chk("model_carry", m, {16'h4000, 5'b00001});
    m = model(0, 0, 8'h7F, 12'hFFC, 0, 0, 0, 0);  chk("model_ovf", m, {16'h7F80, 5'b00101});
    m = model(0, 0, 8'h81, 12'h800, 0, 0, 0, 0);  chk("model_unf", m, {16'h0000, 5'b00011});
    m = model(0, 0, 8'd0, 12'h800, 0, 0, 0, 1);   chk("model_qnan", m, {16'h7FC0, 5'b00000});
    m = model(0, 1, 8'd0, 12'h800, 0, 0, 0, 0);   chk("model_neg", m, {16'h7FC0, 5'b10000});
    m = model(1, 1, 8'd0, 12'h000, 1, 0, 0, 0);   chk("model_inv_zero", m, {16'hFF80, 5'b01000});
    m = model(1, 0, 8'd0, 12'h000, 0, 1, 0, 0);   chk("model_inv_inf", m, {16'h0000, 5'b00000});
    #12;
    chk("reset_valid_o", valid_o, 0);
    chk("reset_res_o", res_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ready_o", ready_o, 1);
    send(0, 0, 8'd1, 12'h800, 0, 0, 0, 0);
    chk("lat_cycle1_valid_o", valid_o, 0);
    @(posedge clk);
    #1 chk("lat_cycle2_valid_o", valid_o, 1);
    chk("lat_cycle2_res_o", res_o, 16'h4000);
    send(0, 0, 8'd0, 12'h818, 0, 0, 0, 0);
    send(0, 0, 8'd0, 12'h828, 0, 0, 0, 0);
    send(0, 0, 8'd0, 12'hFFC, 0, 0, 0, 0);
    send(0, 0, 8'h7F, 12'hFFC, 0, 0, 0, 0);
    send(0, 0, 8'h81, 12'h800, 0, 0, 0, 0);
    send(0, 0, 8'd0, 12'h800, 0, 0, 0, 1);
    send(0, 1, 8'd0, 12'h800, 0, 0, 0, 0);
    send(1, 1, 8'd0, 12'h000, 1, 0, 0, 0);
    send(1, 0, 8'd0, 12'h000, 0, 1, 0, 0);
    send(0, 1, 8'd0, 12'h000, 1, 0, 0, 0);
    send(0, 0, 8'd0, 12'h800, 0, 1, 0, 0);
    send(0, 0, 8'd0, 12'h800, 0, 0, 1, 1);
    drain();
    fork
      begin
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
      for (int i = 0; i < 4; i++) send(0, 0, 8'(i + 1), 12'h800 | 12'(i * 16 + 9), 0, 0, 0, 0);
    join
    drain();
    send(0, 0, 8'd3, 12'h8A0, 0, 0, 0, 0);
    send(0, 0, 8'd4, 12'h8B0, 0, 0, 0, 0);
    rst = 1'b1;
    #1 chk("midrst_valid_o", valid_o, 0);
    chk("midrst_res_o", res_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(0, 0, 8'd2, 12'h9C8, 0, 0, 0, 0);
    drain();
    for (int c = 0; c < 3000; c++) begin
      rand_beat();
      valid_i = $urandom_range(0, 9) < 7;
      ready_i = $urandom_range(0, 9) < 7;
      @(posedge clk);
      #1;
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
